// File: rtl/dmem_responder_if.sv
// Load/store request/response bundle between the CPU datapath and dmem_responder.
interface dmem_responder_if;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic        rdMem;
  logic        wrMem;
  logic [31:0] rdData;
  logic        ready;
  logic        err;
  logic        busy;

  modport master (
    output addr, wrData, rdMem, wrMem,
    input  rdData, ready, err, busy
  );

  modport slave (
    input  addr, wrData, rdMem, wrMem,
    output rdData, ready, err, busy
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT cycles, then pulses ready.
// Optional DMEM_STATS_EN adds saturating read/write/error response counters.
module dmem_responder #(
  parameter int unsigned AW   = 8,
  parameter int unsigned WAIT = 2
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rdCount,
  output logic [15:0]       wrCount,
  output logic [7:0]        errCount
`endif
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  cnt, cnt_d;

  logic [AW-1:0]  cap_idx;
  logic [DW-1:0]  cap_data;
  logic           cap_rd, cap_wr, cap_err;

  logic [DW-1:0]  rd_data_q;
  logic           ready_q, err_q, busy_q;

  logic [DW-1:0]  mem [DEPTH];

  logic           req_c, req_err_c, accept_c, enter_resp_c;
  logic [AW-1:0]  eff_idx_c;
  logic [DW-1:0]  eff_data_c;
  logic           eff_rd_c, eff_wr_c, eff_err_c;
  logic           mem_we_c, rd_load_c;

  // Out-of-range upper address bits are an error, never an alias.
  assign req_c     = bus.rdMem | bus.wrMem;
  assign req_err_c = (bus.rdMem & bus.wrMem) | ((bus.addr >> AW) != '0);

  // Next state plus the strobes for the edge that enters RESP.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    accept_c     = 1'b0;
    eff_idx_c    = cap_idx;
    eff_data_c   = cap_data;
    eff_rd_c     = cap_rd;
    eff_wr_c     = cap_wr;
    eff_err_c    = cap_err;
    enter_resp_c = 1'b0;
    mem_we_c     = 1'b0;
    rd_load_c    = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_c) begin
          accept_c = 1'b1;
          if (WAIT == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt == '0) state_d = S_RESP;
        else           cnt_d   = cnt - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // With zero wait states the access happens on the acceptance edge itself.
    if (state == S_IDLE) begin
      eff_idx_c  = bus.addr[AW-1:0];
      eff_data_c = bus.wrData;
      eff_rd_c   = bus.rdMem;
      eff_wr_c   = bus.wrMem;
      eff_err_c  = req_err_c;
    end

    enter_resp_c = (state_d == S_RESP) && (state != S_RESP);
    mem_we_c     = enter_resp_c & eff_wr_c & ~eff_err_c & rst;
    rd_load_c    = enter_resp_c & eff_rd_c & ~eff_err_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cap_idx   <= '0;
      cap_data  <= '0;
      cap_rd    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_err   <= 1'b0;
      rd_data_q <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      if (accept_c) begin
        cap_idx  <= bus.addr[AW-1:0];
        cap_data <= bus.wrData;
        cap_rd   <= bus.rdMem;
        cap_wr   <= bus.wrMem;
        cap_err  <= req_err_c;
      end
      if (rd_load_c) rd_data_q <= mem[eff_idx_c];
      ready_q <= enter_resp_c;
      err_q   <= enter_resp_c & eff_err_c;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Storage array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[eff_idx_c] <= eff_data_c;
  end

  assign bus.rdData = rd_data_q;
  assign bus.ready  = ready_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;

`ifdef DMEM_STATS_EN
  // Counters advance during the RESP cycle and stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdCount  <= '0;
      wrCount  <= '0;
      errCount <= '0;
    end else if (state == S_RESP) begin
      if (cap_err) begin
        if (errCount != '1) errCount <= errCount + 1'b1;
      end else if (cap_rd) begin
        if (rdCount != '1) rdCount <= rdCount + 1'b1;
      end else if (cap_wr) begin
        if (wrCount != '1) wrCount <= wrCount + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with WAIT=2, one with WAIT=0.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_responder_if b2 ();
  dmem_responder_if b0 ();

`ifdef DMEM_STATS_EN
  logic [15:0] rc2, wc2, rc0, wc0;
  logic [7:0]  ec2, ec0;
`endif

  dmem_responder #(.AW(8), .WAIT(2)) u_w2 (
    .clk(clk), .rst(rst), .bus(b2)
`ifdef DMEM_STATS_EN
    , .rdCount(rc2), .wrCount(wc2), .errCount(ec2)
`endif
  );

  dmem_responder #(.AW(8), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst), .bus(b0)
`ifdef DMEM_STATS_EN
    , .rdCount(rc0), .wrCount(wc0), .errCount(ec0)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      b0.rdMem = rd; b0.wrMem = wr; b0.addr = a; b0.wrData = d;
    end else begin
      b2.rdMem = rd; b2.wrMem = wr; b2.addr = a; b2.wrData = d;
    end
  endtask

  function automatic logic get_ready(input bit sel);
    return sel ? b0.ready : b2.ready;
  endfunction

  function automatic logic get_busy(input bit sel);
    return sel ? b0.busy : b2.busy;
  endfunction

  // One request; lat = cycle index after acceptance (1-based) in which ready is seen.
  task automatic run_req(input bit sel, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic [31:0] rdd, output logic e,
                         output logic bsy, output logic rdy_after, output logic bsy_after);
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 1;
    while (!get_ready(sel) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdd = sel ? b0.rdData : b2.rdData;
    e   = sel ? b0.err : b2.err;
    bsy = get_busy(sel);
    @(posedge clk); #1;
    rdy_after = get_ready(sel);
    bsy_after = get_busy(sel);
  endtask

  int          lat;
  logic [31:0] rdd;
  logic        e, bsy, ra, ba;
  int          ready_seen;

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(b2.ready), 32'h0);
    chk("rst_err",   32'(b2.err),   32'h0);
    chk("rst_busy",  32'(b2.busy),  32'h0);
    chk("rst_rdata", b2.rdData,     32'h0);
    chk("rst_rdata0", b0.rdData,    32'h0);
    @(negedge clk);
    rst = 1'b1;

    // WAIT=2: write then read addr 5
    run_req(1'b0, 1'b0, 1'b1, 32'h5, 32'hDEADBEEF, lat, rdd, e, bsy, ra, ba);
    chk("w5_lat",   32'(lat), 32'd3);
    chk("w5_err",   32'(e),   32'h0);
    chk("w5_busy",  32'(bsy), 32'h1);
    chk("w5_rdata", rdd,      32'h0);
    chk("w5_ready_after", 32'(ra), 32'h0);
    chk("w5_busy_after",  32'(ba), 32'h0);
    run_req(1'b0, 1'b1, 1'b0, 32'h5, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("r5_lat",   32'(lat), 32'd3);
    chk("r5_rdata", rdd,      32'hDEADBEEF);
    chk("r5_err",   32'(e),   32'h0);

    // Both rdMem and wrMem: error, addr 7 keeps its contents
    run_req(1'b0, 1'b0, 1'b1, 32'h7, 32'h12345678, lat, rdd, e, bsy, ra, ba);
    chk("w7_err", 32'(e), 32'h0);
    run_req(1'b0, 1'b1, 1'b1, 32'h7, 32'hFFFFFFFF, lat, rdd, e, bsy, ra, ba);
    chk("rw7_lat",   32'(lat), 32'd3);
    chk("rw7_err",   32'(e),   32'h1);
    chk("rw7_rdata", rdd,      32'hDEADBEEF);
    chk("rw7_err_after", 32'(b2.err), 32'h0);
    run_req(1'b0, 1'b1, 1'b0, 32'h7, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("r7_rdata", rdd,    32'h12345678);
    chk("r7_err",   32'(e), 32'h0);

    // Out-of-range address: error, rdData holds
    run_req(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("r100_lat",   32'(lat), 32'd3);
    chk("r100_err",   32'(e),   32'h1);
    chk("r100_rdata", rdd,      32'h12345678);

`ifdef DMEM_STATS_EN
    chk("st_rd", 32'(rc2), 32'd2);
    chk("st_wr", 32'(wc2), 32'd2);
    chk("st_er", 32'(ec2), 32'd2);
`endif

    // Reset during WAIT aborts a pending write to addr 9
    run_req(1'b0, 1'b0, 1'b1, 32'h9, 32'h11112222, lat, rdd, e, bsy, ra, ba);
    chk("w9_err", 32'(e), 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'h9, 32'hA5A5A5A5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("abort_busy_wait", 32'(b2.busy), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready", 32'(b2.ready), 32'h0);
    chk("abort_busy",  32'(b2.busy),  32'h0);
    chk("abort_rdata", b2.rdData,     32'h0);
`ifdef DMEM_STATS_EN
    chk("st_rst_rd", 32'(rc2), 32'd0);
    chk("st_rst_wr", 32'(wc2), 32'd0);
    chk("st_rst_er", 32'(ec2), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    ready_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (b2.ready || b2.busy) ready_seen++;
    end
    chk("abort_no_ready", 32'(ready_seen), 32'd0);
    run_req(1'b0, 1'b1, 1'b0, 32'h9, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("r9_rdata", rdd,    32'h11112222);
    chk("r9_err",   32'(e), 32'h0);

    // WAIT=0: write then immediate read of addr 3
    run_req(1'b1, 1'b0, 1'b1, 32'h3, 32'hCAFEF00D, lat, rdd, e, bsy, ra, ba);
    chk("w3_lat",   32'(lat), 32'd1);
    chk("w3_busy",  32'(bsy), 32'h1);
    chk("w3_rdata", rdd,      32'h0);
    chk("w3_busy_after", 32'(ba), 32'h0);
    run_req(1'b1, 1'b1, 1'b0, 32'h3, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("r3_lat",   32'(lat), 32'd1);
    chk("r3_rdata", rdd,      32'hCAFEF00D);
    chk("r3_err",   32'(e),   32'h0);
    run_req(1'b1, 1'b1, 1'b1, 32'h3, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("rw3_lat", 32'(lat), 32'd1);
    chk("rw3_err", 32'(e),   32'h1);
    run_req(1'b1, 1'b1, 1'b0, 32'h3, 32'h0, lat, rdd, e, bsy, ra, ba);
    chk("r3b_rdata", rdd, 32'hCAFEF00D);
`ifdef DMEM_STATS_EN
    chk("st0_rd", 32'(rc0), 32'd2);
    chk("st0_wr", 32'(wc0), 32'd1);
    chk("st0_er", 32'(ec0), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the CPU's load/store port. It accepts rdMem/wrMem requests with addr and wrData, inserts a programmable number of wait states, performs one word access on an internal array, and returns a one-cycle ready pulse with read data.
- Sits between the CPU datapath and the storage array, replacing the zero-latency data_mem so the core can be made stall-aware.

Parameters:
- AW, 8, word-address width; array depth is 2**AW 32-bit words.
- WAIT, 2, wait-state cycles inserted between request acceptance and response (0..15).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  32  word address; addr[AW-1:0] indexes the array, addr[31:AW] must be zero.
- wrData  input  32  store data.
- rdMem  input  1  read request.
- wrMem  input  1  write request.
- rdData  output  32  load data, registered.
- ready  output  1  one-cycle response strobe.
- err  output  1  error flag, valid only while ready=1.
- busy  output  1  high from acceptance until the ready cycle, inclusive.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE, wait counter is 0, and rdData=0, ready=0, err=0, busy=0. Array contents are not cleared. Reset during WAIT or RESP aborts the access; a pending write is never committed.
- States: IDLE, WAIT, RESP.
- IDLE: a request is accepted on the rising edge where rdMem|wrMem=1. addr, wrData, rdMem and wrMem are captured into internal registers. The FSM goes to WAIT if WAIT>0, else to RESP. busy=1 from the edge after acceptance.
- WAIT: the counter is loaded with WAIT-1 at acceptance and decrements each cycle. At 0 the FSM goes to RESP. Inputs are ignored in this state; the captured values are used.
- RESP: ready=1 for exactly one cycle.
  - Read: rdData shows the array word at the captured index.
  - Write: the array word is written on the edge entering RESP; rdData is unchanged.
  - The FSM returns to IDLE on the next edge.
- Latency: ready asserts WAIT+1 cycles after the acceptance edge. Minimum request-to-request spacing is WAIT+2 cycles.
- Error response:
  - Triggered when rdMem and wrMem are both 1, or captured addr[31:AW] is non-zero.
  - The request still takes the full latency and completes with ready=1, err=1.
  - No array write occurs and rdData is unchanged.
- err=0 whenever ready=0.
- Requests held high after ready are treated as new requests in IDLE. A requester must deassert in the cycle after ready to avoid a repeat access.
- Write-then-read to the same address returns the new data.
- Index wrap: there is no wrap. An out-of-range address is an error, never an aliased access.

Optional Feature:
- Macro: DMEM_STATS_EN.
- With the macro defined, three outputs are added:
  - rdCount[15:0]: counts successful read responses.
  - wrCount[15:0]: counts successful write responses.
  - errCount[7:0]: counts error responses.
  - Each counter increments in the RESP cycle, saturates at all-ones and resets to 0 on rst.
- Without the macro, these ports and counters do not exist and the behaviour is otherwise identical.

Test Plan:
- WAIT=2: write 0xDEADBEEF at addr 5, then read addr 5 -> each ready arrives 3 cycles after acceptance, read rdData=0xDEADBEEF, err=0.
- WAIT=0: read immediately after a write to addr 0x3 -> ready the cycle after acceptance; the newly written value is returned.
- rdMem=wrMem=1 at addr 7 (holding 0x12345678) -> ready with err=1; a subsequent read of addr 7 returns 0x12345678.
- Read addr 0x100 with AW=8 -> ready with err=1; rdData holds its previous value.
- Reset pulse during WAIT of a write of 0xA5A5A5A5 to addr 9 -> ready never asserts and busy=0; a later read of addr 9 returns the old contents.
- With DMEM_STATS_EN: 3 reads, 2 writes, 1 error -> rdCount=3, wrCount=2, errCount=1; rst clears all three to 0.
